// File: rtl/sampler_pkg.sv
// Shared types and constants for the constraint rejection sampler.
// Holds the FSM state type, the LFSR feedback mask and the operand field layout.
package sampler_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StHold
    } smp_state_t;

    // Right-shifting Galois mask for x^64+x^63+x^61+x^60+1
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    localparam int unsigned NUM_VARS = 5;
    localparam int unsigned VAR_W   [0:4] = '{13, 13, 14, 14, 8};
    localparam int unsigned VAR_OFS [0:4] = '{0, 13, 26, 40, 54};
    localparam int unsigned CAND_W  = 62;

endpackage

// File: rtl/galois_lfsr64.sv
// 64-bit Galois LFSR with synchronous reset to SEED, parallel load and step enable.
// Load takes priority over stepping; zero-seed handling is done by the parent.
module galois_lfsr64
    import sampler_pkg::*;
#(
    parameter logic [63:0] SEED = 64'h9E37_79B9_7F4A_7C15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [63:0] load_val,
    output logic [63:0] q
);

    logic [63:0] lfsr_q;
    logic [63:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (en) begin
            lfsr_d = {1'b0, lfsr_q[63:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 64'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/constraint_rejection_sampler.sv
// Rejection sampler: an LFSR proposes candidate operand vectors, satisfying ones
// are captured and streamed out over valid/ready until the run is done or times out.
module constraint_rejection_sampler
    import sampler_pkg::*;
#(
    parameter logic [63:0] SEED      = 64'h9E37_79B9_7F4A_7C15,
    parameter int unsigned MAX_TRIES = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             seed_load,
    input  logic [63:0]      seed_in,
    output logic [12:0]      cand_var_0,
    output logic [12:0]      cand_var_1,
    output logic [13:0]      cand_var_2,
    output logic [13:0]      cand_var_3,
    output logic [7:0]       cand_var_4,
    input  logic             sat_in,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [12:0]      sample_var_0,
    output logic [12:0]      sample_var_1,
    output logic [13:0]      sample_var_2,
    output logic [13:0]      sample_var_3,
    output logic [7:0]       sample_var_4,
    output logic             busy,
    output logic             timeout,
    output logic [CNT_W-1:0] try_count,
    output logic [CNT_W-1:0] samples_left
);

    localparam logic [CNT_W-1:0] TRY_LAST = CNT_W'(MAX_TRIES - 1);

    smp_state_t        state_q, state_d;
    logic [CNT_W-1:0]  samples_left_q, samples_left_d;
    logic [CNT_W-1:0]  try_count_q, try_count_d;
    logic              timeout_q, timeout_d;
    logic [CAND_W-1:0] sample_q, sample_d;

    logic        lfsr_en;
    logic        lfsr_load;
    logic [63:0] lfsr_load_val;
    logic [63:0] lfsr_q;
    logic [CAND_W-1:0] cand;
    logic        unused_lfsr_hi;

    galois_lfsr64 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (lfsr_en),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .q        (lfsr_q)
    );

    assign lfsr_load_val  = (seed_in == 64'd0) ? SEED : seed_in;
    assign cand           = lfsr_q[CAND_W-1:0];
    assign unused_lfsr_hi = ^lfsr_q[63:CAND_W];

    always_comb begin
        state_d        = state_q;
        samples_left_d = samples_left_q;
        try_count_d    = try_count_q;
        timeout_d      = timeout_q;
        sample_d       = sample_q;
        lfsr_en        = 1'b0;
        lfsr_load      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A seed load in the same cycle as start suppresses the start
                if (seed_load) begin
                    lfsr_load = 1'b1;
                end else if (start) begin
                    samples_left_d = (num_samples == '0) ? CNT_W'(1) : num_samples;
                    try_count_d    = '0;
                    timeout_d      = 1'b0;
                    state_d        = StSearch;
                end
            end
            StSearch: begin
                lfsr_en = 1'b1;
                if (sat_in) begin
                    sample_d = cand;
                    state_d  = StHold;
                end else if (try_count_q == TRY_LAST) begin
                    timeout_d      = 1'b1;
                    samples_left_d = '0;
                    state_d        = StIdle;
                end else begin
                    try_count_d = try_count_q + CNT_W'(1);
                end
            end
            StHold: begin
                if (sample_ready) begin
                    samples_left_d = samples_left_q - CNT_W'(1);
                    try_count_d    = '0;
                    state_d        = (samples_left_q == CNT_W'(1)) ? StIdle : StSearch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            samples_left_q <= '0;
            try_count_q    <= '0;
            timeout_q      <= 1'b0;
            sample_q       <= '0;
        end else begin
            state_q        <= state_d;
            samples_left_q <= samples_left_d;
            try_count_q    <= try_count_d;
            timeout_q      <= timeout_d;
            sample_q       <= sample_d;
        end
    end

    assign cand_var_0 = cand[VAR_OFS[0] +: VAR_W[0]];
    assign cand_var_1 = cand[VAR_OFS[1] +: VAR_W[1]];
    assign cand_var_2 = cand[VAR_OFS[2] +: VAR_W[2]];
    assign cand_var_3 = cand[VAR_OFS[3] +: VAR_W[3]];
    assign cand_var_4 = cand[VAR_OFS[4] +: VAR_W[4]];

    assign sample_var_0 = sample_q[VAR_OFS[0] +: VAR_W[0]];
    assign sample_var_1 = sample_q[VAR_OFS[1] +: VAR_W[1]];
    assign sample_var_2 = sample_q[VAR_OFS[2] +: VAR_W[2]];
    assign sample_var_3 = sample_q[VAR_OFS[3] +: VAR_W[3]];
    assign sample_var_4 = sample_q[VAR_OFS[4] +: VAR_W[4]];

    assign sample_valid = (state_q == StHold);
    assign busy         = (state_q != StIdle);
    assign timeout      = timeout_q;
    assign try_count    = try_count_q;
    assign samples_left = samples_left_q;

endmodule
